// File: rtl/mmcm_ctrl_pkg.sv
// mmcm_ctrl_pkg: shared types, default timing and helpers for the MMCM reset controller.
`timescale 1ns/1ps
package mmcm_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  // Default timing for a 12 MHz input clock
  localparam int DEF_RST_HOLD_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT       = 12000;
  localparam int DEF_LOCK_STABLE_CYCLES = 64;
  localparam int DEF_MAX_RETRIES        = 3;
  localparam int DEF_LOSS_CNT_W         = 8;
  localparam int DEF_GLITCH_CYCLES      = 4;

  // Bits needed to hold the values 0..n-1 (never less than one bit)
  function automatic int ctr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output decode of a state: {mmcm_reset, sys_rst_n, fail}
  function automatic logic [2:0] out_dec(input state_t s);
    return {(s == RESET_HOLD) || (s == FAIL), s == RUN, s == FAIL};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit double-flop synchronizer, async active-low reset, resets to 0.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // Two flops in series give the first stage a full cycle to resolve metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/mmcm_reset_ctrl.sv
// mmcm_reset_ctrl: sequences the MMCM reset, waits for a stable lock, then
// releases the system reset; retries on lock timeout and latches FAIL.
// Optional build macro: LOCK_GLITCH_FILTER_EN (ignore short lock drops in RUN).
`timescale 1ns/1ps
module mmcm_reset_ctrl
  import mmcm_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W,
  parameter int GLITCH_CYCLES      = DEF_GLITCH_CYCLES
) (
  input  logic                                clk_in1,
  input  logic                                reset_n,
  input  logic                                locked,
  input  logic                                restart,
  output logic                                mmcm_reset,
  output logic                                sys_rst_n,
  output logic                                fail,
  output logic [ctr_w(MAX_RETRIES + 1)-1:0]   retry_cnt,
  output logic [LOSS_CNT_W-1:0]               lock_loss_cnt,
  output logic [2:0]                          state
);

  localparam int RETRY_W = ctr_w(MAX_RETRIES + 1);
  // One timer serves every state, so size it for the longest interval
  localparam int TMR_W = ctr_w(max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT),
                                    max2(LOCK_STABLE_CYCLES, GLITCH_CYCLES)));

  localparam logic [TMR_W-1:0]      HOLD_LAST   = TMR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]      STABLE_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TMR_ONE     = TMR_W'(1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_CNT_W-1:0] LOSS_SAT    = '1;
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE    = LOSS_CNT_W'(1);
`ifdef LOCK_GLITCH_FILTER_EN
  localparam logic [TMR_W-1:0]      GLITCH_LAST = TMR_W'(GLITCH_CYCLES - 1);
`endif

  state_t           st;
  logic [TMR_W-1:0] timer;
  logic             locked_s;

  // locked is asynchronous to clk_in1; only the synchronized copy is used
  sync_2ff u_lock_sync (
    .clk   (clk_in1),
    .rst_n (reset_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Sequencer FSM; outputs are registered from the state being entered
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      st            <= RESET_HOLD;
      {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else if (restart) begin
      st        <= RESET_HOLD;
      {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
      timer     <= '0;
      retry_cnt <= '0;
    end else begin
      case (st)
        RESET_HOLD: begin
          if (timer == HOLD_LAST) begin
            st    <= WAIT_LOCK;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(WAIT_LOCK);
            timer <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            st    <= STABLE;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(STABLE);
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer <= '0;
            if (retry_cnt == RETRY_MAX) begin
              st <= FAIL;
              {mmcm_reset, sys_rst_n, fail} <= out_dec(FAIL);
            end else begin
              st        <= RESET_HOLD;
              {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
              retry_cnt <= retry_cnt + RETRY_W'(1);
            end
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            // Lock dropped before proving stable: wait again, same attempt
            st    <= WAIT_LOCK;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(WAIT_LOCK);
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            st        <= RUN;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(RUN);
            timer     <= '0;
            retry_cnt <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
          if (locked_s) begin
            timer <= '0;
          end else if (timer == GLITCH_LAST) begin
            st    <= RESET_HOLD;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
            timer <= '0;
            if (lock_loss_cnt != LOSS_SAT) lock_loss_cnt <= lock_loss_cnt + LOSS_ONE;
          end else begin
            timer <= timer + TMR_ONE;
          end
`else
          if (!locked_s) begin
            st    <= RESET_HOLD;
            {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
            timer <= '0;
            if (lock_loss_cnt != LOSS_SAT) lock_loss_cnt <= lock_loss_cnt + LOSS_ONE;
          end
`endif
        end
        FAIL: begin
          st <= FAIL;
        end
        default: begin
          st    <= RESET_HOLD;
          {mmcm_reset, sys_rst_n, fail} <= out_dec(RESET_HOLD);
          timer <= '0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mmcm_reset_ctrl.sv
// tb_mmcm_reset_ctrl: randomized and directed bench for mmcm_reset_ctrl with a
// phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_mmcm_reset_ctrl;

  localparam int T_HOLD = 4;
  localparam int T_TO   = 20;
  localparam int T_STB  = 8;
  localparam int T_MAXR = 2;
  localparam int LW     = 8;
  localparam int T_GL   = 4;
`ifdef LOCK_GLITCH_FILTER_EN
  localparam int DROP = T_GL;
`else
  localparam int DROP = 1;
`endif

  localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  localparam int S_MMCM = 0, S_SYS = 1, S_FAIL = 2, S_STATE = 3, S_RETRY = 4, S_LOSS = 5;

  logic          clk_in1 = 1'b0;
  logic          reset_n;
  logic          locked;
  logic          restart;
  logic          mmcm_reset;
  logic          sys_rst_n;
  logic          fail;
  logic [1:0]    retry_cnt;
  logic [LW-1:0] lock_loss_cnt;
  logic [2:0]    state;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: current phase, cycles elapsed in it, glitch run, counters
  int m_ph, m_n, m_g, m_retry, m_loss;
  bit lk_q[$];

  mmcm_reset_ctrl #(
    .RST_HOLD_CYCLES    (T_HOLD),
    .LOCK_TIMEOUT       (T_TO),
    .LOCK_STABLE_CYCLES (T_STB),
    .MAX_RETRIES        (T_MAXR),
    .LOSS_CNT_W         (LW),
    .GLITCH_CYCLES      (T_GL)
  ) dut (
    .clk_in1       (clk_in1),
    .reset_n       (reset_n),
    .locked        (locked),
    .restart       (restart),
    .mmcm_reset    (mmcm_reset),
    .sys_rst_n     (sys_rst_n),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  always #41.665 clk_in1 = ~clk_in1;

  initial begin
    #(60000 * 83.33);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int obs(input int sel);
    case (sel)
      S_MMCM:  return int'(mmcm_reset);
      S_SYS:   return int'(sys_rst_n);
      S_FAIL:  return int'(fail);
      S_STATE: return int'(state);
      S_RETRY: return int'(retry_cnt);
      default: return int'(lock_loss_cnt);
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_HOLD; m_n = 0; m_g = 0; m_retry = 0; m_loss = 0;
    lk_q.delete();
    lk_q.push_back(1'b0);
    lk_q.push_back(1'b0);
  endtask

  // One clock edge of the reference: locked is seen two edges late
  task automatic model_step(input bit lk, input bit rs);
    bit ls;
    bit lost;
    ls = lk_q.pop_front();
    lk_q.push_back(lk);
    if (rs) begin
      m_ph = P_HOLD; m_n = 0; m_retry = 0; m_g = 0;
      return;
    end
    case (m_ph)
      P_HOLD: begin
        m_n++;
        if (m_n == T_HOLD) begin m_ph = P_WAIT; m_n = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_ph = P_STAB; m_n = 0;
        end else begin
          m_n++;
          if (m_n == T_TO) begin
            m_n = 0;
            if (m_retry == T_MAXR) m_ph = P_FAIL;
            else begin m_retry++; m_ph = P_HOLD; end
          end
        end
      end
      P_STAB: begin
        if (!ls) begin
          m_ph = P_WAIT; m_n = 0;
        end else begin
          m_n++;
          if (m_n == T_STB) begin m_ph = P_RUN; m_retry = 0; m_g = 0; end
        end
      end
      P_RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
        m_g  = ls ? 0 : m_g + 1;
        lost = (m_g == T_GL);
`else
        lost = !ls;
`endif
        if (lost) begin
          m_ph = P_HOLD; m_n = 0; m_g = 0;
          if (m_loss < (1 << LW) - 1) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  // Advance one clock, update the model, compare every output mid-cycle
  task automatic cycle();
    @(posedge clk_in1);
    model_step(locked, restart);
    @(negedge clk_in1);
    chk("state",         int'(state),         m_ph);
    chk("mmcm_reset",    int'(mmcm_reset),    int'(m_ph == P_HOLD || m_ph == P_FAIL));
    chk("sys_rst_n",     int'(sys_rst_n),     int'(m_ph == P_RUN));
    chk("fail",          int'(fail),          int'(m_ph == P_FAIL));
    chk("retry_cnt",     int'(retry_cnt),     m_retry);
    chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
  endtask

  task automatic run_until(input int sel, input int val, input int bound, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (obs(sel) != val && cnt < bound);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  initial begin
    int cnt, t1, t2, tf;
    reset_n = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in1);
    @(negedge clk_in1);
    chk("rst_state",  int'(state), P_HOLD);
    chk("rst_mmcm",   int'(mmcm_reset), 1);
    chk("rst_sys",    int'(sys_rst_n), 0);
    chk("rst_fail",   int'(fail), 0);
    chk("rst_retry",  int'(retry_cnt), 0);
    chk("rst_loss",   int'(lock_loss_cnt), 0);
    reset_n = 1'b1;

    // Nominal lock
    run_until(S_MMCM, 0, 50, cnt);
    chk("hold_len", cnt, T_HOLD);
    repeat (4) cycle();
    locked = 1'b1;
    run_until(S_SYS, 1, 40, cnt);
    chk("lock_to_run", cnt, 2 + 1 + T_STB);
    chk("nominal_retry", int'(retry_cnt), 0);

    // Lock loss in RUN
    locked = 1'b0;
    cycle();
    locked = 1'b1;
`ifdef LOCK_GLITCH_FILTER_EN
    repeat (10) cycle();
    chk("glitch_sys_held", int'(sys_rst_n), 1);
    chk("glitch_no_count", int'(lock_loss_cnt), 0);
    locked = 1'b0;
    repeat (DROP - 1) cycle();
    cycle();
    locked = 1'b1;
    run_until(S_SYS, 0, 20, cnt);
    chk("loss_latency", cnt + DROP, T_GL + 2);
`else
    run_until(S_SYS, 0, 20, cnt);
    chk("loss_latency", cnt + 1, 3);
`endif
    chk("loss_cnt_one", int'(lock_loss_cnt), 1);
    run_until(S_MMCM, 0, 20, cnt);
    chk("loss_hold_len", cnt, T_HOLD);
    run_until(S_SYS, 1, 60, cnt);
    chk("rerun", int'(sys_rst_n), 1);

    // Restart and lock loss on the same edge
    locked = 1'b0;
    repeat (DROP + 1) cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    locked = 1'b1;
    chk("prio_loss", int'(lock_loss_cnt), 1);
    chk("prio_state", int'(state), P_HOLD);

    // Retries to FAIL
    locked = 1'b0;
    restart = 1'b1;
    t1 = 0; t2 = 0; tf = 0;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      restart = 1'b0;
      if (retry_cnt == 2'd1 && t1 == 0) t1 = c;
      if (retry_cnt == 2'd2 && t2 == 0) t2 = c;
      if (fail) begin tf = c; break; end
    end
    chk("t_retry1", t1, 1 + (T_HOLD + T_TO));
    chk("t_retry2", t2, 1 + 2 * (T_HOLD + T_TO));
    chk("t_fail",   tf, 1 + 3 * (T_HOLD + T_TO));
    repeat (30) cycle();
    chk("fail_sticky", int'(fail), 1);
    chk("fail_mmcm",   int'(mmcm_reset), 1);
    pulse_restart();
    chk("restart_retry", int'(retry_cnt), 0);
    chk("restart_state", int'(state), P_HOLD);
    chk("restart_fail",  int'(fail), 0);

    // Drop during STABLE
    locked = 1'b1;
    run_until(S_STATE, P_STAB, 40, cnt);
    repeat (4) cycle();
    locked = 1'b0;
    repeat (2) cycle();
    locked = 1'b1;
    run_until(S_STATE, P_WAIT, 10, cnt);
    chk("stable_drop_wait", int'(state), P_WAIT);
    chk("stable_drop_sys",  int'(sys_rst_n), 0);
    run_until(S_STATE, P_STAB, 10, cnt);
    run_until(S_SYS, 1, 20, cnt);
    chk("stable_restart", cnt, T_STB);

    // Saturation of the lock-loss counter
    for (int i = 0; i < 260; i++) begin
      repeat ($urandom_range(1, 5)) cycle();
      locked = 1'b0;
      repeat (DROP) cycle();
      locked = 1'b1;
      run_until(S_SYS, 0, 10, cnt);
      run_until(S_SYS, 1, 100, cnt);
    end
    chk("loss_saturated", int'(lock_loss_cnt), (1 << LW) - 1);

    // Randomized lock behaviour with occasional restarts
    for (int i = 0; i < 2500; ) begin
      int len;
      len = $urandom_range(1, 30);
      locked = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < len; j++) begin
        restart = ($urandom_range(0, 199) == 0);
        cycle();
        i++;
      end
    end
    restart = 1'b0;

    // Asynchronous reset while in RUN
    locked = 1'b1;
    pulse_restart();
    run_until(S_SYS, 1, 100, cnt);
    chk("pre_async_run", int'(sys_rst_n), 1);
    #10;
    reset_n = 1'b0;
    #5;
    chk("async_state", int'(state), P_HOLD);
    chk("async_mmcm",  int'(mmcm_reset), 1);
    chk("async_sys",   int'(sys_rst_n), 0);
    chk("async_fail",  int'(fail), 0);
    chk("async_retry", int'(retry_cnt), 0);
    chk("async_loss",  int'(lock_loss_cnt), 0);
    model_reset();
    @(posedge clk_in1);
    @(negedge clk_in1);
    reset_n = 1'b1;
    run_until(S_SYS, 1, 100, cnt);
    chk("post_async_run", int'(sys_rst_n), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
